// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional performance counters are built when DCACHE_PERF_EN is defined.
module dcache_wt #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_read_en,
  input  logic        ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [3:0]  ram_select,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        is_cache_hit,
  output logic        mem_en,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_select,
  output logic [31:0] mem_write_data,
  input  logic        cache_flush,
  input  logic [31:0] mem_read_data
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_access_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {StIdle, StFill} state_e;

  state_e             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];
  logic [IDX_W-1:0]   r_fill_idx;
  logic [TAG_W-1:0]   r_fill_tag;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_line_hit;
  logic               w_rd;
  logic               w_wr;
  logic               w_miss;
  logic               w_unused;

  assign w_idx      = ram_addr[IDX_W+1:2];
  assign w_tag      = ram_addr[31:IDX_W+2];
  assign w_line_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr       = ram_en && ram_write_en;
  assign w_rd       = ram_en && ram_read_en && !ram_write_en;
  assign w_miss     = (r_state == StIdle) && w_rd && !w_line_hit;
  assign w_unused   = ^ram_addr[1:0];

  always_comb begin
    is_cache_hit   = 1'b1;
    ram_read_data  = '0;
    mem_en         = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_select     = '0;
    mem_write_data = '0;
    if (r_state == StFill) begin
      is_cache_hit = 1'b0;
    end else begin
      if (w_line_hit) ram_read_data = r_data[w_idx];
      if (w_wr) begin
        mem_en         = 1'b1;
        mem_write_en   = 1'b1;
        mem_addr       = {ram_addr[31:2], 2'b00};
        mem_select     = ram_select;
        mem_write_data = ram_write_data;
      end else if (w_miss) begin
        is_cache_hit = 1'b0;
        mem_en       = 1'b1;
        mem_read_en  = 1'b1;
        mem_addr     = {ram_addr[31:2], 2'b00};
        mem_select   = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_fill_idx <= '0;
      r_fill_tag <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_miss) begin
            r_state    <= StFill;
            r_fill_idx <= w_idx;
            r_fill_tag <= w_tag;
          end
          if (cache_flush) r_valid <= '0;
        end
        StFill: begin
          r_state <= StIdle;
          // Flush wins over the fill: the line stays invalid and the held read misses again.
          if (cache_flush) r_valid <= '0;
          else             r_valid[r_fill_idx] <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether contents matter.
  always_ff @(posedge clk) begin
    if (r_state == StFill) begin
      r_data[r_fill_idx] <= mem_read_data;
      r_tag[r_fill_idx]  <= r_fill_tag;
    end else if (w_wr && w_line_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_select[b]) r_data[w_idx][8*b +: 8] <= ram_write_data[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_access_cnt <= '0;
      perf_miss_cnt   <= '0;
    end else begin
      if (w_rd && is_cache_hit && (perf_access_cnt != 32'hFFFF_FFFF)) begin
        perf_access_cnt <= perf_access_cnt + 32'd1;
      end
      if (w_miss && (perf_miss_cnt != 32'hFFFF_FFFF)) begin
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: expected memory transactions and read data are queued by
// stimulus and popped by a monitor whenever the DUT issues a memory access or completes a read.
module tb_dcache_wt;

  logic        clk;
  logic        rst;
  logic        ram_en;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [31:0] ram_addr;
  logic [3:0]  ram_select;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        is_cache_hit;
  logic        mem_en;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_select;
  logic [31:0] mem_write_data;
  logic        cache_flush;
  logic [31:0] mem_read_data;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_access_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  dcache_wt #(.LINES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_en         (ram_en),
    .ram_read_en    (ram_read_en),
    .ram_write_en   (ram_write_en),
    .ram_addr       (ram_addr),
    .ram_select     (ram_select),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .is_cache_hit   (is_cache_hit),
    .mem_en         (mem_en),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_select     (mem_select),
    .mem_write_data (mem_write_data),
    .cache_flush    (cache_flush),
    .mem_read_data  (mem_read_data)
`ifdef DCACHE_PERF_EN
    ,
    .perf_access_cnt(perf_access_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem_m [logic [31:0]];
  int          n_chk = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears the cycle after the read is issued.
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (mem_en && mem_read_en) begin
      mem_read_data <= mem_m[mem_addr];
    end else if (mem_en && mem_write_en) begin
      tmp = mem_m[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_select[b]) tmp[8*b +: 8] = mem_write_data[8*b +: 8];
      mem_m[mem_addr] = tmp;
    end
  end

  // Monitor
  always @(negedge clk) begin
    mem_txn_t    e;
    logic [31:0] d;
    if (!rst) begin
      if (mem_en) begin
        n_chk++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_unexpected got wr=%b rd=%b addr=%h, expected no access",
                   mem_write_en, mem_read_en, mem_addr);
        end else begin
          e = mem_q.pop_front();
          if (mem_write_en !== e.wr || mem_read_en !== !e.wr || mem_addr !== e.addr ||
              mem_select !== e.sel || (e.wr && mem_write_data !== e.wdata)) begin
            n_err++;
            $display("FAIL mem_txn got wr=%b rd=%b addr=%h sel=%h wdata=%h, expected wr=%b addr=%h sel=%h wdata=%h",
                     mem_write_en, mem_read_en, mem_addr, mem_select, mem_write_data,
                     e.wr, e.addr, e.sel, e.wdata);
          end
        end
      end
      if (ram_en && ram_read_en && !ram_write_en && is_cache_hit) begin
        n_chk++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected got data=%h, expected no completion", ram_read_data);
        end else begin
          d = rd_q.pop_front();
          if (ram_read_data !== d) begin
            n_err++;
            $display("FAIL rd_data got %h expected %h", ram_read_data, d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    mem_txn_t e;
    e.wr = wr; e.addr = a; e.sel = s; e.wdata = d;
    mem_q.push_back(e);
  endtask

  // Hold a read until it completes; optionally pulse cache_flush after flush_at stall cycles.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int exp_st,
                         input int flush_at, input string nm);
    int   st;
    logic done;
    for (int i = 0; i < exp_st / 2; i++) push_mem(1'b0, a, 4'hF, 32'h0);
    rd_q.push_back(d);
    ram_addr = a; ram_en = 1'b1; ram_read_en = 1'b1; ram_write_en = 1'b0;
    st = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (is_cache_hit) begin
        done = 1'b1;
        break;
      end
      st++;
      @(posedge clk); #1;
      cache_flush = (st == flush_at);
    end
    @(posedge clk); #1;
    ram_en = 1'b0; ram_read_en = 1'b0; cache_flush = 1'b0;
    n_chk++;
    if (!done || st != exp_st) begin
      n_err++;
      $display("FAIL %s stall got %0d (done=%b) expected %0d", nm, st, done, exp_st);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic with_rd, input string nm);
    push_mem(1'b1, a, s, d);
    ram_addr = a; ram_select = s; ram_write_data = d;
    ram_en = 1'b1; ram_write_en = 1'b1; ram_read_en = with_rd;
    @(negedge clk);
    chk(nm, {31'd0, is_cache_hit}, 32'd1);
    @(posedge clk); #1;
    ram_en = 1'b0; ram_write_en = 1'b0; ram_read_en = 1'b0;
  endtask

  initial begin
    mem_m[32'h0000_0100] = 32'hDEAD_BEEF;
    mem_m[32'h0000_0200] = 32'hCAFE_F00D;
    mem_m[32'h0000_0300] = 32'h0BAD_C0DE;
    mem_m[32'h0000_00FC] = 32'h5555_AAAA;
    mem_read_data = '0;
    rst = 1'b1; ram_en = 1'b0; ram_read_en = 1'b0; ram_write_en = 1'b0;
    ram_addr = '0; ram_select = '0; ram_write_data = '0; cache_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hit", {31'd0, is_cache_hit}, 32'd1);
    chk("rst_rdata", ram_read_data, 32'h0);
    chk("rst_mem_ctl", {29'd0, mem_en, mem_read_en, mem_write_en}, 32'h0);
    chk("rst_mem_addr", mem_addr | mem_write_data | {28'd0, mem_select}, 32'h0);
`ifdef DCACHE_PERF_EN
    chk("rst_perf", perf_access_cnt | perf_miss_cnt, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    do_read(32'h0000_0100, 32'hDEAD_BEEF, 2, -1, "cold_read");
    do_read(32'h0000_0100, 32'hDEAD_BEEF, 0, -1, "hit_read");
    do_write(32'h0000_0100, 4'b0011, 32'h1234_5678, 1'b0, "write_hit");
    do_read(32'h0000_0100, 32'hDEAD_5678, 0, -1, "merged_read");
    do_write(32'h0000_0200, 4'hF, 32'h1122_3344, 1'b0, "write_miss");
    do_read(32'h0000_0200, 32'h1122_3344, 2, -1, "no_alloc_read");
    do_read(32'h0000_0100, 32'hDEAD_5678, 2, -1, "evicted_read");
    do_write(32'h0000_0100, 4'b1100, 32'hAABB_0000, 1'b1, "write_with_rd");
    do_read(32'h0000_0100, 32'hAABB_5678, 0, -1, "wr_rd_merge");

    cache_flush = 1'b1;
    @(posedge clk); #1;
    cache_flush = 1'b0;
    do_read(32'h0000_0100, 32'hAABB_5678, 2, -1, "post_flush_read");
    do_read(32'h0000_0300, 32'h0BAD_C0DE, 4, 1, "flush_in_fill");
    do_read(32'h0000_0300, 32'h0BAD_C0DE, 0, -1, "refill_hit");

    push_mem(1'b0, 32'h0000_0200, 4'hF, 32'h0);
    ram_addr = 32'h0000_0200; ram_en = 1'b1; ram_read_en = 1'b1;
    @(negedge clk);
    chk("rst_fill_stall", {31'd0, is_cache_hit}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; ram_en = 1'b0; ram_read_en = 1'b0;
    @(negedge clk);
    chk("rst_fill_abort", {29'd0, is_cache_hit, mem_en, mem_read_en}, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(32'h0000_0300, 32'h0BAD_C0DE, 2, -1, "post_rst_read");
    do_read(32'h0000_00FC, 32'h5555_AAAA, 2, -1, "last_idx_cold");
    do_read(32'h0000_00FC, 32'h5555_AAAA, 0, -1, "last_idx_hit");

`ifdef DCACHE_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(32'h0000_0100, 32'hAABB_5678, 2, -1, "perf_cold");
    do_read(32'h0000_0100, 32'hAABB_5678, 0, -1, "perf_hit1");
    do_read(32'h0000_0100, 32'hAABB_5678, 0, -1, "perf_hit2");
    chk("perf_access", perf_access_cnt, 32'd3);
    chk("perf_miss", perf_miss_cnt, 32'd1);
`endif

    repeat (2) @(posedge clk);
    chk("mem_q_empty", mem_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between `cpu_core`'s data-memory port and `data_ram`. Core reads hit from a register array with no stall. Misses refill one word from `data_ram` and stall the core through `is_cache_hit`. Writes pass straight through to memory in one cycle and update the line when it is resident.

## Interface
- `LINES`, 64: number of one-word lines, a power of two ≥ 2; `IDX_W = $clog2(LINES)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ram_en`  in  1  core request valid.
- `ram_read_en`  in  1  core read.
- `ram_write_en`  in  1  core write; wins if asserted together with `ram_read_en`.
- `ram_addr`  in  32  byte address; bits [1:0] ignored.
- `ram_select`  in  4  byte-lane enables for writes.
- `ram_write_data`  in  32  write data.
- `ram_read_data`  out  32  hit word, full 32 bits; the core does lane extraction.
- `is_cache_hit`  out  1  1 means the request completes this cycle; 0 means stall and hold the request.
- `mem_en`, `mem_read_en`, `mem_write_en`  out  1 each  `data_ram` controls.
- `mem_addr`  out  32  word-aligned `data_ram` address.
- `mem_select`  out  4  `data_ram` byte-lane enables.
- `mem_write_data`  out  32  `data_ram` write data.
- `mem_read_data`  in  32  `data_ram` read data, valid the cycle after a read is issued.
- `cache_flush`  in  1  single-cycle invalidate-all.
- `perf_access_cnt`, `perf_miss_cnt`  out  32 each  present only with `DCACHE_PERF_EN`.

## Operation
- Address split:
  - index = `ram_addr[IDX_W+1:2]`.
  - tag = `ram_addr[31:IDX_W+2]`.
- Per line state: `valid`, `tag`, and a 32-bit `data` word.
- FSM states: IDLE, FILL.
- IDLE, no request (`ram_en`=0): `is_cache_hit`=1; all `mem_*` are 0.
- IDLE, read hit (valid and tag equal):
  - `is_cache_hit`=1 and `ram_read_data`=line data, combinationally.
  - No memory access.
- IDLE, read miss:
  - `is_cache_hit`=0.
  - Same cycle: `mem_en`=1, `mem_read_en`=1, `mem_addr`={`ram_addr[31:2]`,2'b00}, `mem_select`=4'hF.
  - Latch index and tag; go to FILL.
- FILL:
  - `is_cache_hit`=0; `mem_*` deasserted.
  - At the edge, write `mem_read_data` into the latched line, set its tag and set valid=1.
  - Return to IDLE; the held request then hits.
- IDLE, write (`ram_write_en`=1, with or without `ram_read_en`):
  - `is_cache_hit`=1, never stalls.
  - Same cycle: `mem_en`=1, `mem_write_en`=1, `mem_addr` word-aligned, `mem_select`=`ram_select`, `mem_write_data`=`ram_write_data`.
  - Write hit: at the edge, merge bytes whose select bit is 1 into the line.
  - Write miss: line untouched.
- The core must hold all request inputs stable while `is_cache_hit`=0. Request changes during FILL are ignored; the fill uses the latched index and tag.
- `cache_flush`:
  - At the edge, clears every valid bit.
  - In FILL, it takes priority: the fill data is discarded (line stays invalid) and the FSM returns to IDLE, so the held read misses again.
  - In IDLE with a read miss in the same cycle: the memory read is still issued and FILL is entered.
  - A write hit in the same cycle leaves the line invalid.

## Timing
- Read hit: 0 cycles of stall.
- Read miss: the request is presented at cycle 0; `is_cache_hit`=0 in cycles 0 and 1, and =1 with valid data in cycle 2.
- Write: completes in the cycle presented; memory commits at that edge.
- Write directly after a miss-fill to the same line: the line already holds fill data, so the merge applies.
- Reset values:
  - state=IDLE; all valid=0; tag and data arrays need not be reset.
  - Latched index and tag = 0; perf counters = 0.
  - With `ram_en`=0: `is_cache_hit`=1, `ram_read_data` =0 when no hit, all `mem_*`=0.
- Reset asserted mid-FILL aborts the fill; the line stays invalid.

## Configuration
- Macro: `DCACHE_PERF_EN`.
- Defined:
  - `perf_access_cnt` increments on each cycle with `ram_en` & `ram_read_en` & !`ram_write_en` & `is_cache_hit`, i.e. each completed read.
  - `perf_miss_cnt` increments on each IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by `rst`.
- Undefined: both ports and the counter logic are absent; behaviour is otherwise identical.

## Test plan
- Cold read of 0x0000_0100 with mem word 0xDEAD_BEEF → `is_cache_hit` 0,0,1; one `mem_read_en` pulse at mem_addr 0x100; cycle 2 data 0xDEAD_BEEF. Repeat read → hit in cycle 0, no mem access.
- Read 0x100 (filled), then write 0x100 select 4'b0011 data 0x1234_5678 → mem write same cycle, no stall; next read returns 0xDEAD_5678 with no miss.
- Write to uncached 0x200 → mem write issued; next read of 0x200 misses (no allocate).
- With `LINES`=64, fill 0x100, then read 0x200 (same index 0, different tag) → miss and refill; reread of 0x100 misses again.
- Assert `cache_flush` during FILL of 0x100 → line stays invalid and the read re-misses (two `mem_read_en` pulses total); `rst` mid-FILL → IDLE, valid=0, `mem_*`=0.
- With `DCACHE_PERF_EN`: cold read plus two hits → access=3, miss=1.
